// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle for regfile_sb: operand addresses, issue controls,
// writeback strobe, plus the registered operands and the stall flag.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              rd_en;
  logic [ADDR_W-1:0] dst;
  logic              dst_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_en;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              stall;

  modport master (
    output rs, rt, rd_en, dst, dst_en, wb_addr, wb_data, wb_en,
    input  A, B, stall
  );

  modport slave (
    input  rs, rt, rd_en, dst, dst_en, wb_addr, wb_data, wb_en,
    output A, B, stall
  );
endinterface

// File: rtl/regfile_sb.sv
// Decode-stage register file: two registered read ports, write-to-read bypass,
// optional hard-wired zero register and a busy scoreboard that drives stall.
// Optional simulation trace of writes/busy-sets: define REGFILE_SB_TRACE_EN.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] op_a, op_b;
  logic              haz_a, haz_b;
  logic              stall_c, issue;
  logic              wr_ok, set_ok;

  function automatic logic writable(input logic [ADDR_W-1:0] addr);
    return !((ZERO_REG != 0) && (addr == '0));
  endfunction

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (bus.wb_en && (bus.wb_addr == bus.rs) && writable(bus.rs))
      op_a = bus.wb_data;
    else if (writable(bus.rs))
      op_a = regs[bus.rs];
    if (bus.wb_en && (bus.wb_addr == bus.rt) && writable(bus.rt))
      op_b = bus.wb_data;
    else if (writable(bus.rt))
      op_b = regs[bus.rt];

    // A writeback landing this cycle resolves the hazard on its address.
    haz_a   = busy[bus.rs] && !(bus.wb_en && (bus.wb_addr == bus.rs));
    haz_b   = busy[bus.rt] && !(bus.wb_en && (bus.wb_addr == bus.rt));
    stall_c = bus.rd_en && (haz_a || haz_b);
    issue   = bus.rd_en && !stall_c;
    wr_ok   = bus.wb_en && writable(bus.wb_addr);
    set_ok  = issue && bus.dst_en && writable(bus.dst);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Set is written last so a new producer wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (bus.wb_en) busy[bus.wb_addr] <= 1'b0;
      if (set_ok)    busy[bus.dst]     <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (issue) begin
      a_q <= op_a;
      b_q <= op_b;
    end
  end

  assign bus.A     = a_q;
  assign bus.B     = b_q;
  assign bus.stall = stall_c;

`ifdef REGFILE_SB_TRACE_EN
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      if (wr_ok)
        $display("%0t: r%0d <= %0d (0x%h)", $time, bus.wb_addr, bus.wb_data, bus.wb_data);
      if (set_ok)
        $display("%0t: issue busy r%0d", $time, bus.dst);
    end
  end
`endif
`else
`endif
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised, clocked register file for the decode stage, with two registered read ports and one writeback port.
- Adds same-cycle write-to-read bypass, a hard-wired zero register, and a per-register busy scoreboard that raises a stall when an operand has an outstanding write.
- Sits between instruction decode (rs/rt/rd fields) and the execute-stage operand latches; writeback drives the write port.

Parameters:
- DATA_W, 32, width of each register and of the read/write data.
- ADDR_W, 5, register index width; number of registers NREG = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 always reads 0 and is never written or marked busy; when 0 it is an ordinary register.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs  in  ADDR_W  read address, port A.
- rt  in  ADDR_W  read address, port B.
- rd_en  in  1  decode is presenting a valid instruction this cycle.
- dst  in  ADDR_W  destination register of the decoding instruction.
- dst_en  in  1  the decoding instruction writes dst; only meaningful with rd_en.
- wb_addr  in  ADDR_W  writeback address.
- wb_data  in  DATA_W  writeback data.
- wb_en  in  1  writeback strobe.
- A  out  DATA_W  registered operand A.
- B  out  DATA_W  registered operand B.
- stall  out  1  combinational; the current instruction cannot issue.

Behaviour:
- Reset (asynchronous, immediate): all NREG registers = 0, all busy bits = 0, A = 0, B = 0. stall = 0 as a consequence.
- Zero rule (ZERO_REG=1): any address 0 read returns 0. Writes to 0 are dropped. busy[0] is never set.
- Write: on posedge with wb_en, REG[wb_addr] <= wb_data, subject to the zero rule.
- Bypass operand: opA = wb_data if (wb_en && wb_addr==rs && rs is writable), else REG[rs]. opB uses the same rule with rt.
- Busy hazard: hazA = busy[rs] && !(wb_en && wb_addr==rs). hazB is the same with rt.
  - A writeback in the current cycle clears the hazard for that address.
- stall = rd_en && (hazA || hazB).
- Issue: issue = rd_en && !stall.
- Operand latch (1-cycle read latency):
  - On posedge with issue: A <= opA, B <= opB.
  - Otherwise A and B hold their values.
- Scoreboard update on each posedge, in priority order:
  1. if wb_en: busy[wb_addr] <= 0;
  2. if issue && dst_en && dst writable: busy[dst] <= 1.
  - Set has priority over clear when dst == wb_addr in the same cycle: the new producer owns the register.
- Stalled instructions never set busy bits and never update A/B. Decode is expected to hold rs/rt/dst stable while stall=1.
- One outstanding write per register is supported. A second issue to a busy dst simply keeps busy=1, and the first writeback clears it. Ordering of multiple in-flight writes to one register is the pipeline's responsibility.
- Reset asserted mid-operation discards all busy bits and register contents; any writeback in flight at that time is lost.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: REGFILE_SB_TRACE_EN.
- When defined: on every posedge where a write is actually performed, the block prints via $display: "%0t: r%0d <= %0d (0x%h)" with time, address and data. Issue events print "%0t: issue busy r%0d" when a busy bit is set.
  - Simulation only; the trace code is excluded from synthesis.
- When undefined: no display statements are compiled. Functional behaviour is identical.

Test Plan:
- Reset then read: assert rst, release. rs=3, rt=7, rd_en=1 for one clock -> A=0, B=0, stall=0.
- Write/read: wb_en=1, wb_addr=2, wb_data=100. Next cycle rs=2, rd_en=1 -> A=100 after one clock.
- Zero register: wb_en with wb_addr=0, wb_data=55, then read rs=0 -> A=0. Issuing dst=0 with dst_en never causes a stall on rs=0.
- Bypass: in a single cycle wb_en=1, wb_addr=5, wb_data=7, rs=5, rd_en=1 -> stall=0, and A=7 after the edge.
- Scoreboard stall:
  - Issue dst=4, dst_en=1. Next cycle rs=4, rd_en=1 -> stall=1 and A holds its prior value.
  - Two cycles later wb_en=1, wb_addr=4, wb_data=9 -> stall drops that cycle, A=9 after the edge, busy[4]=0.
- Simultaneous set/clear and reset mid-flight:
  - In the same cycle wb_en=1, wb_addr=6 and issue with dst=6, dst_en=1 -> busy[6]=1 afterwards, so a later read of rt=6 stalls.
  - Asserting rst while busy[6]=1 clears the stall immediately and resets A=B=0.
